// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the supported operand width ceiling.
package adder_pkg;

  // 2'd3 is never entered on purpose; the FSM treats it as a return to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand the sequencer is intended to be built with.
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder.
//
// Handshake rules (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds valid and
// its payload steady until that edge; ready may be asserted at any time
// and never depends combinationally on valid. The adder raises in_ready
// only in IDLE and out_valid only in DONE, so the two channels never
// transfer on the same edge.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;

  // Requester / result consumer side.
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

  // Adder side.
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

endinterface

// File: rtl/serial_add_bit.sv
// One-bit full adder cell; the only arithmetic in the serial adder.
module serial_add_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: accepts A, B and carry-in, walks them LSB
// first through a single full-adder cell for WIDTH cycles, then presents
// sum, unsigned carry-out and signed overflow until the consumer takes it.
// WIDTH is expected in 1..WIDTH_MAX.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus,
  output state_t              o_dbg_state
);

  // Counter holds 0..WIDTH without wrapping.
  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic [WIDTH-1:0]   w_sum_shifted;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   r_out_sum;
  logic               r_out_cout;
  logic               r_out_ovf;

  logic               w_s;
  logic               w_co;
  logic               w_accept;
  logic               w_last;

  serial_add_bit u_bit (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_co)
  );

  // Accept and last-slice qualifiers.
  always_comb begin
    w_accept = 1'b0;
    w_last   = 1'b0;
    w_accept = (r_state == IDLE) && bus.in_valid;
    w_last   = (r_cnt == LAST_CNT);
  end

  // Sum shift register input: new bit enters at the MSB end.
  always_comb begin
    w_sum_shifted            = r_sum_sh >> 1;
    w_sum_shifted[WIDTH-1]   = w_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    w_state_next = IDLE;
    case (r_state)
      IDLE:    w_state_next = bus.in_valid  ? RUN  : IDLE;
      RUN:     w_state_next = w_last        ? DONE : RUN;
      DONE:    w_state_next = bus.out_ready ? IDLE : DONE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand load on accept, one bit slice per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sh  <= bus.in_a;
      r_b_sh  <= bus.in_b;
      r_carry <= bus.in_cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_sum_sh <= w_sum_shifted;
      r_carry  <= w_co;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // Result capture on the MSB slice. r_carry at that point is the carry
  // into the MSB, so overflow is that carry XOR the final carry-out.
  // These registers hold through DONE and the following IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_sum  <= '0;
      r_out_cout <= 1'b0;
      r_out_ovf  <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_out_sum  <= w_sum_shifted;
      r_out_cout <= w_co;
      r_out_ovf  <= r_carry ^ w_co;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == RUN) || (r_state == DONE);
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cout  = r_out_cout;
  assign bus.out_ovf   = r_out_ovf;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit and a 1-bit instance share clock
// and reset. Inputs change and outputs are sampled on the falling edge.
module tb_serial_adder_ctrl;
  import adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();
  state_t dbg8;
  state_t dbg1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus8.slave),
    .o_dbg_state (dbg8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus1.slave),
    .o_dbg_state (dbg1)
  );

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_pass;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  // ---------------- driver tasks ----------------
  // Present one operand set on the 8-bit unit and wait for the result.
  // Returns at a falling edge with out_valid high (or after the bound).
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      output logic [7:0] sum, output logic cout, output logic ovf,
                      output int lat);
    int n;
    bus8.in_a      = a;
    bus8.in_b      = b;
    bus8.in_cin    = cin;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b0;
    n = 0;
    while (!bus8.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    // Operands are only sampled at the accepting edge.
    bus8.in_valid = 1'b0;
    bus8.in_a     = ~a;
    bus8.in_b     = 8'h00;
    bus8.in_cin   = ~cin;
    lat = 0;
    while (!bus8.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    sum  = bus8.out_sum;
    cout = bus8.out_cout;
    ovf  = bus8.out_ovf;
  endtask

  // Output handshake on the 8-bit unit.
  task automatic take8();
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("take8_valid_low", 32'(bus8.out_valid), 32'd0);
    check("take8_in_ready", 32'(bus8.in_ready), 32'd1);
  endtask

  task automatic run1(input logic a, input logic b, input logic cin,
                      input logic exp_sum, input logic exp_cout, input logic exp_ovf);
    int lat;
    bus1.in_a      = a;
    bus1.in_b      = b;
    bus1.in_cin    = cin;
    bus1.in_valid  = 1'b1;
    bus1.out_ready = 1'b0;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("w1_latency", 32'(lat), 32'd1);
    check("w1_sum", 32'(bus1.out_sum), 32'(exp_sum));
    check("w1_cout", 32'(bus1.out_cout), 32'(exp_cout));
    check("w1_ovf", 32'(bus1.out_ovf), 32'(exp_ovf));
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
    check("w1_back_idle", 32'(bus1.in_ready), 32'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t       vecs[7];
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         lat;
    int         prev_acc;
    int         n;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] full;
    logic [9:0] exp_v;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sum: 8'h96, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    vecs[3] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[4] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 8'h12, b: 8'h34, cin: 1'b1, sum: 8'h47, cout: 1'b0, ovf: 1'b0};
    vecs[6] = '{a: 8'hC8, b: 8'h9C, cin: 1'b1, sum: 8'h65, cout: 1'b1, ovf: 1'b1};

    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_cin = 1'b0; bus8.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0; bus1.out_ready = 1'b0;

    // Reset state, observed while reset is held.
    bus8.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_sum", 32'(bus8.out_sum), 32'd0);
    check("rst_cout_ovf", 32'({bus8.out_cout, bus8.out_ovf}), 32'd0);
    check("rst_state", 32'(dbg8), 32'(IDLE));
    bus8.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Table of directed vectors.
    for (int i = 0; i < 7; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, sum, cout, ovf, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      take8();
      check($sformatf("vec%0d_sum_hold", i), 32'(bus8.out_sum), 32'(vecs[i].sum));
    end

    // out_ready while idle has no effect.
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("idle_ready_state", 32'(dbg8), 32'(IDLE));
    check("idle_ready_sum_hold", 32'(bus8.out_sum), 32'h65);

    // Backpressure with a competing request held during DONE.
    run8(8'h20, 8'h07, 1'b0, sum, cout, ovf, lat);
    check("bp_first_sum", 32'(sum), 32'h27);
    bus8.in_a = 8'h11; bus8.in_b = 8'h22; bus8.in_cin = 1'b0; bus8.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(bus8.out_valid), 32'd1);
      check("bp_sum_stable", 32'(bus8.out_sum), 32'h27);
      check("bp_in_ready_low", 32'(bus8.in_ready), 32'd0);
    end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("bp_no_same_cycle_accept", 32'(dbg8), 32'(IDLE));
    lat = 0;
    while (!bus8.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    bus8.in_valid = 1'b0;
    check("bp_second_latency", 32'(lat), 32'd9);
    check("bp_second_sum", 32'(bus8.out_sum), 32'h33);
    take8();

    // Reset on the third RUN edge of 0x12+0x34.
    bus8.in_a = 8'h12; bus8.in_b = 8'h34; bus8.in_cin = 1'b0; bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_run_busy", 32'(bus8.busy), 32'd0);
    check("rst_run_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_run_state", 32'(dbg8), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h01, 8'h02, 1'b0, sum, cout, ovf, lat);
    check("after_rst_latency", 32'(lat), 32'd8);
    check("after_rst_sum", 32'(sum), 32'h03);
    take8();

    // Reset while the result is waiting in DONE.
    run8(8'h12, 8'h34, 1'b0, sum, cout, ovf, lat);
    check("done_rst_pre_sum", 32'(sum), 32'h46);
    #2 rst_n = 1'b0;
    #1;
    check("done_rst_valid", 32'(bus8.out_valid), 32'd0);
    check("done_rst_sum", 32'(bus8.out_sum), 32'd0);
    check("done_rst_busy", 32'(bus8.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: in_valid held, out_ready held, random operands.
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    prev_acc = -1;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      bus8.in_a = ra; bus8.in_b = rb; bus8.in_cin = rc;
      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      exp_q.push_back({(ra[7] == rb[7]) && (full[7] != ra[7]), full[8], full[7:0]});
      n = 0;
      while (!bus8.in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (prev_acc >= 0) check($sformatf("b2b%0d_spacing", i), 32'(cyc + 1 - prev_acc), 32'd10);
      prev_acc = cyc + 1;
      @(negedge clk);
      n = 0;
      while (!bus8.out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      exp_v = exp_q.pop_front();
      check($sformatf("b2b%0d_result", i), 32'({bus8.out_ovf, bus8.out_cout, bus8.out_sum}), 32'(exp_v));
    end
    bus8.in_valid = 1'b0;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    @(negedge clk);

    // One-bit build.
    run1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    run1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
